// File: rtl/inst_loader.sv
// Byte-stream program loader: packs little-endian bytes into 32-bit words,
// writes them to instruction memory and holds the core in reset until done.
module inst_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] load_len,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              imem_we,
    output logic [ADDR_W+1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              core_rst_n
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state_r;
    state_t            state_s;
    logic [ADDR_W-1:0] len_r;
    logic [ADDR_W-1:0] word_idx_r;
    logic [ADDR_W-1:0] asm_cnt_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       asm_r;
    logic              xfer_s;
    logic              fire_s;
    logic              last_s;
    logic              launch_s;

    logic              in_ready_r;
    logic              imem_we_r;
    logic [ADDR_W+1:0] imem_addr_r;
    logic [31:0]       imem_wdata_r;
    logic              busy_r;
    logic              done_r;
    logic              core_rst_n_r;

    // Next-state decode; asm_cnt_r counts assembled words, so the last word is
    // recognised on its 4th byte, one cycle before its write strobe.
    always_comb begin
        state_s  = state_r;
        launch_s = 1'b0;
        xfer_s   = (state_r == LOAD) && in_valid;
        fire_s   = xfer_s && (byte_cnt_r == 2'd3);
        last_s   = fire_s && (asm_cnt_r == (len_r - ADDR_W'(1)));
        case (state_r)
            IDLE, DONE: begin
                if (start) begin
                    if (load_len != '0) begin
                        state_s  = LOAD;
                        launch_s = 1'b1;
                    end else begin
                        state_s = DONE;
                    end
                end else begin
                    state_s = state_r;
                end
            end
            LOAD: begin
                if (last_s) begin
                    state_s = FLUSH;
                end else begin
                    state_s = LOAD;
                end
            end
            FLUSH:   state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // State register and status flags, registered from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            in_ready_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            core_rst_n_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            in_ready_r   <= (state_s == LOAD);
            busy_r       <= (state_s == LOAD) || (state_s == FLUSH);
            done_r       <= (state_s == DONE);
            core_rst_n_r <= (state_s == DONE);
        end
    end

    // Byte assembly and word counters; a reset discards any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r      <= '0;
            word_idx_r <= '0;
            asm_cnt_r  <= '0;
            byte_cnt_r <= 2'd0;
            asm_r      <= 24'd0;
        end else if (launch_s) begin
            len_r      <= load_len;
            word_idx_r <= '0;
            asm_cnt_r  <= '0;
            byte_cnt_r <= 2'd0;
            asm_r      <= 24'd0;
        end else if (xfer_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            case (byte_cnt_r)
                2'd0:    asm_r[7:0]   <= in_data;
                2'd1:    asm_r[15:8]  <= in_data;
                2'd2:    asm_r[23:16] <= in_data;
                default: asm_r        <= asm_r;
            endcase
            if (fire_s) begin
                asm_cnt_r  <= asm_cnt_r + ADDR_W'(1);
                word_idx_r <= word_idx_r + ADDR_W'(1);
            end
        end
    end

    // Memory write port; address and data hold their last written values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we_r    <= 1'b0;
            imem_addr_r  <= '0;
            imem_wdata_r <= 32'd0;
        end else begin
            imem_we_r <= fire_s;
            if (fire_s) begin
                imem_addr_r  <= {word_idx_r, 2'b00};
                imem_wdata_r <= {in_data, asm_r};
            end
        end
    end

    assign in_ready   = in_ready_r;
    assign imem_we    = imem_we_r;
    assign imem_addr  = imem_addr_r;
    assign imem_wdata = imem_wdata_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign core_rst_n = core_rst_n_r;

endmodule
